// File: rtl/dmem_pkg.sv
// dmem_pkg: FSM state type, funct3 size/sign codes and legality helper shared by the data memory responder
package dmem_pkg;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  function automatic logic f3_legal(input logic [2:0] f);
    return f inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction
endpackage

// File: rtl/dmem_lane_fmt.sv
// dmem_lane_fmt: load byte/half extraction with sign/zero extension and store lane merge
// ports: word (current memory word), wdata (store data), addr (byte offset), funct3 (size/sign),
//        rdata (formatted load data), wword (word with store lanes merged in)
module dmem_lane_fmt
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] word,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        addr,
  input  logic [2:0]        funct3,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] wword
);
  logic is_b, is_h;
  logic [7:0] b;
  logic [15:0] h;
  // anything that is not B/H is handled as a word; halfwords use addr[1] only (aligned down)
  always_comb begin
    is_b = funct3 inside {F3_B, F3_BU};
    is_h = funct3 inside {F3_H, F3_HU};
    b = word[{addr, 3'b000} +: 8];
    h = word[{addr[1], 4'b0000} +: 16];
    rdata = is_b ? {{(DATA_W-8){b[7] & ~funct3[2]}}, b}
          : is_h ? {{(DATA_W-16){h[15] & ~funct3[2]}}, h} : word;
    wword = word;
    if (is_b) wword[{addr, 3'b000} +: 8] = wdata[7:0];
    else if (is_h) wword[{addr[1], 4'b0000} +: 16] = wdata[15:0];
    else wword = wdata;
  end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: wait-stated byte-addressable data memory with a valid/ready request side and one-cycle response strobe
// ports: clk, reset (sync, active-high); req_valid/req_ready handshake, req_we/req_re/req_addr/req_wdata/req_funct3;
//        rsp_valid strobe, rsp_rdata formatted load data, rsp_err rejection flag
// optional: define DMEM_ERR_EN to reject misaligned/illegal/conflicting accesses instead of aligning them down
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DM_ADDRESS  = 9,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic                  req_re,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err
);
  logic [DATA_W-1:0] mem [2**(DM_ADDRESS-2)];
  state_t state;
  logic [3:0] cnt;
  logic l_we, l_re;
  logic [DM_ADDRESS-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata;
  logic [2:0] l_funct3;
  logic idle, fire, err, a_we, a_re;
  logic [DM_ADDRESS-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata, word, fmt_rdata, wword;
  logic [2:0] a_funct3;
  // with zero wait states the access happens on the accepting edge, so it must see the live request
  always_comb begin
    idle = state == S_IDLE;
    a_we = idle ? req_we : l_we;
    a_re = idle ? req_re : l_re;
    a_addr = idle ? req_addr : l_addr;
    a_wdata = idle ? req_wdata : l_wdata;
    a_funct3 = idle ? req_funct3 : l_funct3;
    fire = (state == S_WAIT && cnt == 4'd0) || (idle && req_valid && WAIT_CYCLES == 0);
    word = mem[a_addr[DM_ADDRESS-1:2]];
`ifdef DMEM_ERR_EN
    err = (a_we && a_re) || !f3_legal(a_funct3)
        || (a_funct3 inside {F3_H, F3_HU} && a_addr[0])
        || (a_funct3 == F3_W && a_addr[1:0] != 2'b00);
`else
    err = 1'b0;
`endif
  end
  dmem_lane_fmt #(.DATA_W(DATA_W)) u_fmt (
    .word(word),
    .wdata(a_wdata),
    .addr(a_addr[1:0]),
    .funct3(a_funct3),
    .rdata(fmt_rdata),
    .wword(wword)
  );
  always_ff @(posedge clk)
    if (!reset && fire && a_we && !err) mem[a_addr[DM_ADDRESS-1:2]] <= wword;
  always_ff @(posedge clk)
    if (reset) begin
      state <= S_IDLE;
      cnt <= 4'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
    end else begin
      rsp_valid <= fire;
      if (fire) begin
        rsp_rdata <= (a_re && !err) ? fmt_rdata : '0;
        rsp_err <= err;
      end
      case (state)
        S_IDLE: if (req_valid) begin
          l_we <= req_we;
          l_re <= req_re;
          l_addr <= req_addr;
          l_wdata <= req_wdata;
          l_funct3 <= req_funct3;
          cnt <= 4'(WAIT_CYCLES - 1);
          state <= fire ? S_RESP : S_WAIT;
          req_ready <= 1'b0;
        end
        S_WAIT: if (fire) state <= S_RESP;
                else cnt <= cnt - 4'd1;
        default: begin
          state <= S_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed self-checking bench for data_mem_responder (WAIT_CYCLES=1)
module tb_data_mem_responder;
  logic clk = 0, reset = 1, req_valid = 0, req_we = 0, req_re = 0;
  logic [8:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [2:0] req_funct3 = '0;
  logic req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  data_mem_responder dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_re(req_re), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_funct3(req_funct3), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // called at a negedge with the DUT idle; returns at the negedge after the response cycle
  task automatic access(input string tag, input logic we, input logic re, input logic [8:0] a,
                        input logic [31:0] wd, input logic [2:0] f3,
                        input logic [31:0] exp_rd, input logic exp_err);
    int lat;
    chk({tag, "_ready"}, req_ready, 1);
    req_valid = 1; req_we = we; req_re = re; req_addr = a; req_wdata = wd; req_funct3 = f3;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 2);
    chk({tag, "_rdata"}, rsp_rdata, exp_rd);
    chk({tag, "_err"}, rsp_err, exp_err);
    @(negedge clk);
    chk({tag, "_valid_drop"}, rsp_valid, 0);
    chk({tag, "_hold"}, rsp_rdata, exp_rd);
  endtask
  initial begin
    logic [31:0] w10;
    int nrsp;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    chk("rst_ready", req_ready, 1);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", rsp_err, 0);
    access("sw10", 1, 0, 9'h010, 32'hDEADBEEF, 3'b010, 0, 0);
    access("lw10", 0, 1, 9'h010, 0, 3'b010, 32'hDEADBEEF, 0);
    access("lb13", 0, 1, 9'h013, 0, 3'b000, 32'hFFFFFFDE, 0);
    access("lbu13", 0, 1, 9'h013, 0, 3'b100, 32'h000000DE, 0);
    access("lh12", 0, 1, 9'h012, 0, 3'b001, 32'hFFFFDEAD, 0);
    access("lhu10", 0, 1, 9'h010, 0, 3'b101, 32'h0000BEEF, 0);
    access("sb11", 1, 0, 9'h011, 32'h00000012, 3'b000, 0, 0);
    access("lw10b", 0, 1, 9'h010, 0, 3'b010, 32'hDEAD12EF, 0);
    access("lb11", 0, 1, 9'h011, 0, 3'b000, 32'h00000012, 0);
    access("sw14", 1, 0, 9'h014, 32'h11223344, 3'b010, 0, 0);
    access("sh16", 1, 0, 9'h016, 32'hABCD8001, 3'b001, 0, 0);
    access("lh16", 0, 1, 9'h016, 0, 3'b001, 32'hFFFF8001, 0);
    access("lw14", 0, 1, 9'h014, 0, 3'b010, 32'h80013344, 0);
    access("lbu17", 0, 1, 9'h017, 0, 3'b100, 32'h00000080, 0);
    access("noop", 0, 0, 9'h010, 32'hFFFFFFFF, 3'b010, 0, 0);
`ifdef DMEM_ERR_EN
    access("sw12_mis", 1, 0, 9'h012, 32'hCAFEF00D, 3'b010, 0, 1);
    w10 = 32'hDEAD12EF;
    access("lw10_after_mis", 0, 1, 9'h010, 0, 3'b010, w10, 0);
`else
    access("sw12_mis", 1, 0, 9'h012, 32'hCAFEF00D, 3'b010, 0, 0);
    w10 = 32'hCAFEF00D;
    access("lw10_after_mis", 0, 1, 9'h010, 0, 3'b010, w10, 0);
`endif
    req_valid = 1; req_we = 0; req_re = 1; req_addr = 9'h010; req_funct3 = 3'b010;
    nrsp = 0;
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("stream_ready_%0d", k), req_ready, (k % 3 == 0) ? 1 : 0);
      chk($sformatf("stream_valid_%0d", k), rsp_valid, (k % 3 == 2) ? 1 : 0);
      if (rsp_valid) begin
        nrsp++;
        chk($sformatf("stream_rdata_%0d", k), rsp_rdata, w10);
      end
      @(negedge clk);
    end
    req_valid = 0;
    chk("stream_count", 32'(nrsp), 3);
    @(negedge clk);
    access("sw18", 1, 0, 9'h018, 32'h55555555, 3'b010, 0, 0);
    req_valid = 1; req_we = 1; req_re = 0; req_addr = 9'h018; req_wdata = 32'h77777777; req_funct3 = 3'b010;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    reset = 1;
    @(negedge clk);
    chk("rst_mid_valid", rsp_valid, 0);
    reset = 0;
    @(negedge clk);
    chk("rst_mid_ready", req_ready, 1);
    chk("rst_mid_rdata", rsp_rdata, 0);
    nrsp = 0;
    repeat (3) begin
      if (rsp_valid) nrsp++;
      @(negedge clk);
    end
    chk("rst_mid_no_rsp", 32'(nrsp), 0);
    access("lw18_after_rst", 0, 1, 9'h018, 0, 3'b010, 32'h55555555, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DM_ADDRESS, default 9, byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter WAIT_CYCLES, default 1, extra wait states per access (0..15).
REQ-004 SHALL have port clk, input, 1, clock; reset is reset, synchronous, active-high, on clock clk.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port req_valid, input, 1, request present.
REQ-007 SHALL have port req_ready, output, 1, responder can accept a request.
REQ-008 SHALL have port req_we, input, 1, store request.
REQ-009 SHALL have port req_re, input, 1, load request.
REQ-010 SHALL have port req_addr, input, DM_ADDRESS, byte address.
REQ-011 SHALL have port req_wdata, input, DATA_W, store data.
REQ-012 SHALL have port req_funct3, input, 3, access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-013 SHALL have port rsp_valid, output, 1, one-cycle response strobe.
REQ-014 SHALL have port rsp_rdata, output, DATA_W, formatted load data.
REQ-015 SHALL have port rsp_err, output, 1, access rejected.

Function
REQ-016 SHALL hold 2^(DM_ADDRESS-2) words of DATA_W bits, indexed by req_addr[DM_ADDRESS-1:2], little-endian byte lanes.
REQ-017 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; IDLE -> RESP directly when WAIT_CYCLES=0.
REQ-018 SHALL drive req_ready=1 only in IDLE; accept when req_valid && req_ready, latching we, re, addr, wdata, funct3.
REQ-019 SHALL, in WAIT, count WAIT_CYCLES cycles (counter loaded WAIT_CYCLES-1 at accept, decremented to 0), then enter RESP.
REQ-020 SHALL assert rsp_valid for exactly one cycle, in RESP, i.e. cycle N+1+WAIT_CYCLES for acceptance at cycle N.
REQ-021 SHALL perform the store and register rsp_rdata/rsp_err on the clock edge entering RESP; rsp_rdata and rsp_err SHALL hold until the next RESP.
REQ-022 SHALL, for loads, extract byte/halfword at addr[1:0]/addr[1] and sign-extend (000, 001) or zero-extend (100, 101); word (010) unchanged.
REQ-023 SHALL, for stores, write only the addressed lanes (SB: 1 byte, SH: 2 bytes, SW: 4 bytes) from the low bits of req_wdata; other bytes unchanged.
REQ-024 SHALL treat a request with req_we=req_re=0 as a no-op that still responds (rsp_rdata=0, rsp_err=0).
REQ-025 SHALL ignore req_valid outside IDLE (no queuing, no overwrite of latched request).
REQ-026 SHALL make a store visible to any later accepted load (no bypass needed, as accesses are serialized).

Reset
REQ-027 SHALL, on reset, force state IDLE, wait counter 0, req_ready=1 from the next cycle, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-028 SHALL, on reset mid-access, abandon the access with no write and no response; memory array contents are not reset.

Configuration
REQ-029 SHALL, with DMEM_ERR_EN defined, set rsp_err=1 and suppress the write for misaligned H/W accesses, funct3 in {011,110,111}, or req_we && req_re; rsp_rdata=0 on error.
REQ-030 SHALL, without DMEM_ERR_EN, tie rsp_err=0, align addresses down (H: clear bit 0, W: clear bits 1:0), and treat illegal funct3 as W.

Structure
REQ-031 SHALL take the FSM state enum and funct3 size/sign localparams from shared package dmem_pkg.
REQ-032 SHALL place load extraction/extension and store lane merge in combinational sub-module dmem_lane_fmt.

Verification
REQ-033 SHALL cover: SW addr 0x010 data 0xDEADBEEF, then LW 0x010 -> rsp_rdata 0xDEADBEEF, rsp_valid at accept+2 (WAIT_CYCLES=1).
REQ-034 SHALL cover: after REQ-033, LB 0x013 -> 0xFFFFFFDE; LBU 0x013 -> 0x000000DE; LH 0x012 -> 0xFFFFDEAD; LHU 0x010 -> 0x0000BEEF.
REQ-035 SHALL cover: SB 0x011 data 0x12 over 0xDEADBEEF, then LW 0x010 -> 0xDEAD12EF.
REQ-036 SHALL cover: with DMEM_ERR_EN, SW 0x012 -> rsp_err=1, subsequent LW 0x010 unchanged; without, write lands at 0x010.
REQ-037 SHALL cover: req_valid held high continuously -> req_ready low during WAIT/RESP, exactly one response per acceptance, acceptances spaced WAIT_CYCLES+2 cycles.
REQ-038 SHALL cover: reset asserted in WAIT of a SW -> no rsp_valid, target word unchanged, req_ready=1 the cycle after reset deasserts.
